fpadd_stream_ctrl: RTL and testbench
====================================

// Module: fpadd_stream_ctrl
// PURPOSE
//  Sequencer for a fixed-latency, non-stallable FloPoCo FP adder (FPAdd_8_23 family, 34-bit
//  {exn[1:0],IEEE754} operands). Streams LEN element pairs from two operand memories into the
//  adder, tracks in-flight slots through a valid/address shift register matched to pipeline
//  latency, and writes IEEE754 results back. Sits between the shell memory ports and the adder.
// PARAMETERS
//  DATAW  32  IEEE754 single word width (adder side is DATAW+2)
//  ADDRW  10  element address width; max vector length 2**ADDRW
//  LAT    7   adder pipeline latency in cycles (X/Y sampled -> R valid)
// PORTS
//  clk        in   1          clock, all logic on rising edge
//  rst_n      in   1          synchronous reset, active low
//  start      in   1          begin a run (sampled in IDLE only)
//  len        in   ADDRW+1    elements in run, sampled with start; 0 legal
//  src_valid  in   1          shell can serve a read this cycle; 0 = insert bubble
//  rd_en      out  1          read strobe to both operand memories
//  rd_addr    out  ADDRW      element index read
//  rd_data0   in   DATAW      operand X word, valid 1 cycle after rd_en
//  rd_data1   in   DATAW      operand Y word, valid 1 cycle after rd_en
//  fpa_x      out  DATAW+2    adder X = {exn, rd_data0}
//  fpa_y      out  DATAW+2    adder Y = {exn, rd_data1}
//  fpa_r      in   DATAW+2    adder result
//  wr_en      out  1          result write strobe
//  wr_addr    out  ADDRW      result index
//  wr_data    out  DATAW      result, IEEE754
//  busy       out  1          run in progress (RUN or DRAIN)
//  done       out  1          one-cycle pulse at end of run
// BEHAVIOUR
//  Reset: state=IDLE; rd_en, wr_en, busy, done = 0; rd_addr, wr_addr, wr_data = 0; valid pipe cleared.
//  FSM: IDLE -start&len!=0-> RUN; IDLE -start&len==0-> DONE; RUN -last issue-> DRAIN;
//   DRAIN -last wr_en-> DONE; DONE -> IDLE (done=1 for exactly this cycle). start outside IDLE ignored.
//  Issue (RUN): rd_en = src_valid; on rd_en rd_addr=idx, idx++; idx starts 0, last issue idx=len-1.
//   src_valid=0 -> rd_en=0, idx holds, bubble enters valid pipe. Issue is combinational on src_valid.
//  Input encode (comb on rd_dataN): exp==0 -> exn 00 (denormals flushed to zero); exp==FF & man==0
//   -> 10; exp==FF & man!=0 -> 11; else 01. Low DATAW bits passed unchanged.
//  Tracking: shift reg of depth LAT+1 carrying {valid, addr}; entry pushed each cycle (valid=rd_en).
//   Adder never stalls; bubbles ride along. wr_en/wr_addr = tail entry; total issue->wr_en = LAT+1 cycles.
//  Output decode of fpa_r (comb, registered with wr_en? no: wr_data comb from fpa_r, qualified by wr_en):
//   exn 00 -> {sign,31'b0}; 01 -> fpa_r[DATAW-1:0]; 10 -> {sign,8'hFF,23'b0}; 11 -> 32'h7FC00000.
//  Outstanding counter (ADDRW+1 bits): +1 on rd_en, -1 on wr_en, both same cycle -> unchanged.
//   DRAIN exits when counter reaches 0 on a wr_en; done asserted next cycle.
//  len==0: no rd_en/wr_en, busy stays 0, done pulses 1 cycle after start.
//  len==2**ADDRW: idx wraps to 0 only after last issue; no extra reads.
//  Reset mid-run: pipe cleared same edge, in-flight results discarded (no wr_en), no done pulse.
//  busy = (state==RUN)|(state==DRAIN).
// TESTING
//  T1 len=16, src_valid=1, X=Y=4.14+i -> wr_data[i]=realtobits(2*(4.14+i)), wr_en exactly 8
//     cycles after matching rd_en, 16 writes, done pulse 1 cycle after 16th write.
//  T2 len=16, src_valid random ~10% low -> same 16 results in order, rd_en=0 when src_valid=0,
//     gaps in wr_en mirror gaps in rd_en shifted 8 cycles.
//  T3 specials: +inf+1.0 -> 7F800000; NaN(7FC00001)+1.0 -> 7FC00000; 0+0 -> 00000000;
//     denormal 00000001+0 -> 00000000; -0+-0 -> 80000000.
//  T4 len=0 -> no rd_en/wr_en, busy=0, done=1 one cycle after start.
//  T5 start re-pulsed with len=3 during len=16 run -> ignored, exactly 16 writes, one done.
//  T6 rst_n low 3 cycles after start (len=16) -> no wr_en afterward, outputs at reset values;
//     following start len=4 completes with 4 correct writes.

Source files
------------

// File: rtl/fpadd_stream_ctrl.sv
// fpadd_stream_ctrl
//   Streams LEN operand pairs from two operand memories into a fixed-latency,
//   non-stallable FloPoCo FP adder. The adder takes {exn[1:0], IEEE754} operands.
//   Results are written back as plain IEEE754 words. A valid/address shift
//   register, matched to the adder latency, tracks each slot in flight.
//
// Ports
//   clk, rst_n           clock (rising edge), synchronous active-low reset
//   start, len           launch a run of len elements (sampled in IDLE only)
//   src_valid            shell can serve a read this cycle
//   rd_en, rd_addr       read strobe / element index to both operand memories
//   rd_data0, rd_data1   operand words, valid one cycle after rd_en
//   fpa_x, fpa_y         adder operands in FloPoCo format
//   fpa_r                adder result in FloPoCo format
//   wr_en, wr_addr       result write strobe / element index
//   wr_data              IEEE754 result, zero when wr_en is low
//   busy, done           run in progress / one-cycle end-of-run pulse
//   dbg_state            current FSM state, for observation only
//
// Handshake: the shell raises src_valid when it can serve a read in that
// cycle. In RUN, rd_en mirrors src_valid combinationally, and each rd_en
// consumes exactly one element. Neither the adder nor the write port can
// stall. wr_en is therefore a pure strobe with no back-pressure.
module fpadd_stream_ctrl #(
    parameter int DATAW = 32,
    parameter int ADDRW = 10,
    parameter int LAT   = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ADDRW:0]   len,
    input  logic             src_valid,
    output logic             rd_en,
    output logic [ADDRW-1:0] rd_addr,
    input  logic [DATAW-1:0] rd_data0,
    input  logic [DATAW-1:0] rd_data1,
    output logic [DATAW+1:0] fpa_x,
    output logic [DATAW+1:0] fpa_y,
    input  logic [DATAW+1:0] fpa_r,
    output logic             wr_en,
    output logic [ADDRW-1:0] wr_addr,
    output logic [DATAW-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    localparam int EXPW = 8;
    localparam int MANW = DATAW - 1 - EXPW;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [ADDRW-1:0] idx_q, idx_d;
    logic [ADDRW:0]   len_q, len_d;
    logic [ADDRW:0]   outst_q, outst_d;
    logic [LAT:0]     vld_q;
    logic [ADDRW-1:0] adr_q [0:LAT];
    logic             last_issue;
    logic [DATAW-1:0] dec;
    logic             r_sign;

    // Denormals map to exn 00, so the adder sees them as zero.
    function automatic logic [1:0] exn_of(input logic [DATAW-1:0] w);
        logic [EXPW-1:0] e;
        logic [MANW-1:0] m;
        e = w[DATAW-2 -: EXPW];
        m = w[MANW-1:0];
        if (e == '0)
            exn_of = 2'b00;
        else if (e == '1)
            exn_of = (m == '0) ? 2'b10 : 2'b11;
        else
            exn_of = 2'b01;
    endfunction

    assign fpa_x = {exn_of(rd_data0), rd_data0};
    assign fpa_y = {exn_of(rd_data1), rd_data1};

    assign rd_en      = (state_q == S_RUN) && src_valid;
    assign rd_addr    = rd_en ? idx_q : '0;
    assign last_issue = rd_en && ({1'b0, idx_q} == (len_q - 1'b1));

    // Bubbles carry address 0, so the tail address is already zero when idle.
    assign wr_en   = vld_q[LAT];
    assign wr_addr = adr_q[LAT];

    assign r_sign = fpa_r[DATAW-1];
    always_comb begin
        dec = '0;
        case (fpa_r[DATAW+1:DATAW])
            2'b00:   dec = {r_sign, {(DATAW-1){1'b0}}};
            2'b01:   dec = fpa_r[DATAW-1:0];
            2'b10:   dec = {r_sign, {EXPW{1'b1}}, {MANW{1'b0}}};
            default: dec = {1'b0, {EXPW{1'b1}}, 1'b1, {(MANW-1){1'b0}}};
        endcase
    end
    assign wr_data = wr_en ? dec : '0;

    assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        // Simultaneous issue and retire cancel out.
        outst_d = outst_q + {{ADDRW{1'b0}}, rd_en} - {{ADDRW{1'b0}}, wr_en};
        // The index wraps naturally after the final issue of a full-size run.
        if (rd_en)
            idx_d = idx_q + 1'b1;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = len;
                    idx_d   = '0;
                    state_d = (len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_issue)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // The last outstanding slot retires this cycle.
                if (wr_en && (outst_q == {{ADDRW{1'b0}}, 1'b1}))
                    state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            outst_q <= '0;
            vld_q   <= '0;
            for (int i = 0; i <= LAT; i++)
                adr_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            outst_q <= outst_d;
            vld_q   <= {vld_q[LAT-1:0], rd_en};
            adr_q[0] <= rd_addr;
            for (int i = 1; i <= LAT; i++)
                adr_q[i] <= adr_q[i-1];
        end
    end

endmodule

// File: tb/tb_fpadd_stream_ctrl.sv
module tb_fpadd_stream_ctrl;

    localparam int DATAW = 32;
    localparam int ADDRW = 10;
    localparam int LAT   = 7;
    localparam int DEPTH = 1 << ADDRW;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             start = 1'b0;
    logic [ADDRW:0]   len = '0;
    logic             src_valid = 1'b0;
    logic             rd_en, wr_en, busy, done;
    logic [ADDRW-1:0] rd_addr, wr_addr;
    logic [DATAW-1:0] rd_data0 = '0, rd_data1 = '0, wr_data;
    logic [DATAW+1:0] fpa_x, fpa_y, fpa_r;
    logic [1:0]       dbg_state;

    fpadd_stream_ctrl #(.DATAW(DATAW), .ADDRW(ADDRW), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .src_valid(src_valid),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data0(rd_data0), .rd_data1(rd_data1),
        .fpa_x(fpa_x), .fpa_y(fpa_y), .fpa_r(fpa_r), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference arithmetic on IEEE words ----------------
    function automatic real ieee_to_real(input logic [31:0] w);
        logic [63:0] b;
        if (w[30:23] == 8'h00) return 0.0;
        b = {w[31], {3'b000, w[30:23]} + 11'd896, w[22:0], 29'b0};
        return $bitstoreal(b);
    endfunction

    function automatic logic [31:0] real_to_ieee(input real r);
        logic [63:0] b;
        int          e;
        logic [23:0] m;
        b = $realtobits(r);
        if (b[62:52] == 11'd0) return {b[63], 31'b0};
        e = int'(b[62:52]) - 1023 + 127;
        m = {1'b0, b[51:29]};
        if (b[28] && ((|b[27:0]) || b[29])) m = m + 24'd1;
        if (m[23]) begin
            m = '0;
            e = e + 1;
        end
        if (e >= 255) return {b[63], 8'hFF, 23'b0};
        if (e <= 0) return {b[63], 31'b0};
        return {b[63], e[7:0], m[22:0]};
    endfunction

    // Expected write-back word for one operand pair, from IEEE754 rules.
    // Denormals are flushed and NaNs come back canonical.
    function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
        logic xnan, ynan, xinf, yinf;
        xnan = (x[30:23] == 8'hFF) && (x[22:0] != 0);
        ynan = (y[30:23] == 8'hFF) && (y[22:0] != 0);
        xinf = (x[30:23] == 8'hFF) && (x[22:0] == 0);
        yinf = (y[30:23] == 8'hFF) && (y[22:0] == 0);
        if (xnan || ynan) return 32'h7FC0_0000;
        if (xinf && yinf) return (x[31] != y[31]) ? 32'h7FC0_0000 : {x[31], 8'hFF, 23'b0};
        if (xinf) return {x[31], 8'hFF, 23'b0};
        if (yinf) return {y[31], 8'hFF, 23'b0};
        if ((x[30:23] == 0) && (y[30:23] == 0)) return {x[31] & y[31], 31'b0};
        return real_to_ieee(ieee_to_real(x) + ieee_to_real(y));
    endfunction

    // Adder stand-in: FloPoCo-format in and out, with junk in the don't-care
    // bits so that the decode has to ignore them.
    function automatic logic [33:0] flopoco_add(input logic [33:0] x, input logic [33:0] y);
        logic [31:0] w;
        real         vx, vy;
        if (x[33:32] == 2'b11 || y[33:32] == 2'b11) return {2'b11, 32'h1234_5678};
        if (x[33:32] == 2'b10 && y[33:32] == 2'b10)
            return (x[31] != y[31]) ? {2'b11, 32'h0BAD_F00D} : {2'b10, x[31], 31'h2AAA_5555};
        if (x[33:32] == 2'b10) return {2'b10, x[31], 31'h1357_9BDF};
        if (y[33:32] == 2'b10) return {2'b10, y[31], 31'h1357_9BDF};
        if (x[33:32] == 2'b00 && y[33:32] == 2'b00) return {2'b00, x[31] & y[31], 31'h7654_3210};
        vx = (x[33:32] == 2'b00) ? 0.0 : ieee_to_real(x[31:0]);
        vy = (y[33:32] == 2'b00) ? 0.0 : ieee_to_real(y[31:0]);
        w = real_to_ieee(vx + vy);
        if (w[30:23] == 8'h00) return {2'b00, w[31], 31'h0F0F_0F0F};
        if (w[30:23] == 8'hFF) return {2'b10, w[31], 31'h7070_7070};
        return {2'b01, w};
    endfunction

    // ---------------- environment models ----------------
    logic [31:0] mem0 [DEPTH];
    logic [31:0] mem1 [DEPTH];
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data0 <= mem0[rd_addr];
            rd_data1 <= mem1[rd_addr];
        end
    end

    logic [33:0] add_pipe [LAT];
    always @(posedge clk) begin
        add_pipe[0] <= flopoco_add(fpa_x, fpa_y);
        for (int i = 1; i < LAT; i++) add_pipe[i] <= add_pipe[i-1];
    end
    assign fpa_r = add_pipe[LAT-1];

    // ---------------- monitor: logs events, compares nothing ----------------
    int               cyc = 0;
    int               rd_cyc_q[$];
    logic [ADDRW-1:0] rd_adr_q[$];
    int               wr_cyc_q[$];
    logic [ADDRW-1:0] wr_adr_q[$];
    logic [DATAW-1:0] wr_dat_q[$];
    int               done_q[$];
    int               busy_cnt = 0;
    int               bad_rd = 0;
    logic [DATAW-1:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rd_en) begin
            rd_cyc_q.push_back(cyc);
            rd_adr_q.push_back(rd_addr);
        end
        if (rd_en && !src_valid) bad_rd = bad_rd + 1;
        if (wr_en) begin
            wr_cyc_q.push_back(cyc);
            wr_adr_q.push_back(wr_addr);
            wr_dat_q.push_back(wr_data);
        end
        if (done) done_q.push_back(cyc);
        if (busy) busy_cnt = busy_cnt + 1;
    end

    task automatic clear_logs();
        rd_cyc_q.delete(); rd_adr_q.delete();
        wr_cyc_q.delete(); wr_adr_q.delete(); wr_dat_q.delete();
        done_q.delete();
        busy_cnt = 0;
        bad_rd = 0;
    endtask

    // ---------------- stimulus fill helpers ----------------
    task automatic fill_ramp(input int n);
        logic [31:0] w;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            w = real_to_ieee(4.14 + real'(i));
            mem0[i] = w;
            mem1[i] = w;
            exp_q.push_back(real_to_ieee(2.0 * (4.14 + real'(i))));
        end
    endtask

    function automatic logic [31:0] rand_normal();
        logic [7:0] e;
        e = 8'($urandom_range(150, 100));
        return {1'($urandom_range(1)), e, 23'($urandom)};
    endfunction

    task automatic fill_random(input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            mem0[i] = rand_normal();
            mem1[i] = rand_normal();
            exp_q.push_back(ref_add(mem0[i], mem1[i]));
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", rd_en); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (wr_addr !== '0 || rd_addr !== '0) begin errors++; $display("FAIL reset_addr got rd %h wr %h want 0", rd_addr, wr_addr); end
        checks++; if (wr_data !== '0) begin errors++; $display("FAIL reset_wr_data got %h want 0", wr_data); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    // One full run of n elements. Each cycle, src_valid is low with
    // probability pct%. If repulse >= 0, a second start with len=3 is raised
    // at that loop step.
    task automatic test_stream(input string tag, input int n, input int pct, input int repulse);
        int s_cyc;
        bit timed_out;
        clear_logs();
        @(posedge clk); #1;
        start = 1'b1;
        len = (ADDRW+1)'(n);
        src_valid = ($urandom_range(99) >= pct);
        s_cyc = cyc;
        timed_out = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            @(posedge clk); #1;
            start = (k == repulse);
            if (k == repulse) len = 11'd3;
            src_valid = ($urandom_range(99) >= pct);
            if (done_q.size() != 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        start = 1'b0;
        src_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        checks++; if (timed_out) begin errors++; $display("FAIL %s timeout: no done within 4000 cycles", tag); end
        checks++; if (rd_cyc_q.size() != n) begin errors++; $display("FAIL %s rd_count got %0d want %0d", tag, rd_cyc_q.size(), n); end
        checks++; if (wr_cyc_q.size() != n) begin errors++; $display("FAIL %s wr_count got %0d want %0d", tag, wr_cyc_q.size(), n); end
        checks++; if (bad_rd != 0) begin errors++; $display("FAIL %s rd_en_without_src_valid got %0d want 0", tag, bad_rd); end
        checks++; if (done_q.size() != 1) begin errors++; $display("FAIL %s done_pulses got %0d want 1", tag, done_q.size()); end
        for (int i = 0; i < n && i < rd_cyc_q.size() && i < wr_cyc_q.size(); i++) begin
            checks++; if (rd_adr_q[i] !== ADDRW'(i)) begin errors++; $display("FAIL %s rd_addr[%0d] got %0d want %0d", tag, i, rd_adr_q[i], i); end
            checks++; if (wr_adr_q[i] !== ADDRW'(i)) begin errors++; $display("FAIL %s wr_addr[%0d] got %0d want %0d", tag, i, wr_adr_q[i], i); end
            checks++; if (wr_cyc_q[i] != rd_cyc_q[i] + LAT + 1) begin errors++; $display("FAIL %s latency[%0d] got %0d want %0d", tag, i, wr_cyc_q[i] - rd_cyc_q[i], LAT + 1); end
            checks++; if (wr_dat_q[i] !== exp_q[i]) begin errors++; $display("FAIL %s wr_data[%0d] got %h want %h", tag, i, wr_dat_q[i], exp_q[i]); end
        end
        if (pct == 0 && rd_cyc_q.size() == n) begin
            checks++; if (rd_cyc_q[0] != s_cyc + 1 || rd_cyc_q[n-1] != s_cyc + n) begin
                errors++; $display("FAIL %s issue_window got %0d..%0d want %0d..%0d", tag, rd_cyc_q[0] - s_cyc, rd_cyc_q[n-1] - s_cyc, 1, n);
            end
        end
        if (done_q.size() == 1 && wr_cyc_q.size() != 0) begin
            checks++; if (done_q[0] != wr_cyc_q[wr_cyc_q.size()-1] + 1) begin
                errors++; $display("FAIL %s done_timing got %0d want %0d", tag, done_q[0], wr_cyc_q[wr_cyc_q.size()-1] + 1);
            end
            checks++; if (busy_cnt != done_q[0] - s_cyc - 1) begin
                errors++; $display("FAIL %s busy_cycles got %0d want %0d", tag, busy_cnt, done_q[0] - s_cyc - 1);
            end
        end
    endtask

    task automatic test_basic();
        fill_ramp(16);
        test_stream("basic", 16, 0, -1);
    endtask

    task automatic test_bubbles();
        fill_ramp(16);
        test_stream("bubbles", 16, 10, -1);
        fill_random(40);
        test_stream("bubbles_rand", 40, 35, -1);
    endtask

    task automatic test_specials();
        logic [31:0] xs [7] = '{32'h7F80_0000, 32'h7FC0_0001, 32'h0000_0000, 32'h0000_0001,
                                32'h8000_0000, 32'hFF80_0000, 32'h3F80_0000};
        logic [31:0] ys [7] = '{32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 32'h0000_0000,
                                32'h8000_0000, 32'h7F80_0000, 32'hBF80_0000};
        logic [31:0] es [7] = '{32'h7F80_0000, 32'h7FC0_0000, 32'h0000_0000, 32'h0000_0000,
                                32'h8000_0000, 32'h7FC0_0000, 32'h0000_0000};
        exp_q.delete();
        for (int i = 0; i < 7; i++) begin
            mem0[i] = xs[i];
            mem1[i] = ys[i];
            exp_q.push_back(es[i]);
        end
        test_stream("specials", 7, 0, -1);
    endtask

    task automatic test_len_zero();
        int s_cyc;
        clear_logs();
        @(posedge clk); #1;
        start = 1'b1;
        len = '0;
        src_valid = 1'b1;
        s_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        src_valid = 1'b0;
        checks++; if (rd_cyc_q.size() != 0 || wr_cyc_q.size() != 0) begin errors++; $display("FAIL len0_strobes got rd %0d wr %0d want 0 0", rd_cyc_q.size(), wr_cyc_q.size()); end
        checks++; if (busy_cnt != 0) begin errors++; $display("FAIL len0_busy got %0d want 0", busy_cnt); end
        checks++; if (done_q.size() != 1) begin errors++; $display("FAIL len0_done_count got %0d want 1", done_q.size()); end
        else begin
            checks++; if (done_q[0] != s_cyc + 1) begin errors++; $display("FAIL len0_done_timing got %0d want %0d", done_q[0] - s_cyc, 1); end
        end
    endtask

    task automatic test_ignore_start();
        fill_random(16);
        test_stream("restart_ignored", 16, 0, 5);
    endtask

    task automatic test_reset_midrun();
        int r_cyc;
        fill_ramp(16);
        clear_logs();
        @(posedge clk); #1;
        start = 1'b1;
        len = 11'd16;
        src_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        r_cyc = cyc;
        @(posedge clk);
        @(negedge clk);
        checks++; if (rd_en !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL midrst_strobes got rd %b wr %b busy %b done %b want 0000", rd_en, wr_en, busy, done);
        end
        checks++; if (rd_addr !== '0 || wr_addr !== '0 || wr_data !== '0) begin
            errors++; $display("FAIL midrst_values got rd_addr %h wr_addr %h wr_data %h want 0", rd_addr, wr_addr, wr_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        src_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++; if (wr_cyc_q.size() != 0) begin errors++; $display("FAIL midrst_writes got %0d want 0 (first at %0d, reset at %0d)", wr_cyc_q.size(), wr_cyc_q.size() != 0 ? wr_cyc_q[0] : -1, r_cyc); end
        checks++; if (done_q.size() != 0) begin errors++; $display("FAIL midrst_done got %0d want 0", done_q.size()); end
        fill_random(4);
        test_stream("after_reset", 4, 0, -1);
    endtask

    task automatic test_back_to_back();
        fill_random(5);
        test_stream("b2b_a", 5, 0, -1);
        fill_random(3);
        test_stream("b2b_b", 3, 20, -1);
        fill_random(1);
        test_stream("single", 1, 0, -1);
    endtask

    task automatic test_max_len();
        fill_random(DEPTH);
        test_stream("max_len", DEPTH, 0, -1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bubbles();
        test_specials();
        test_len_zero();
        test_ignore_start();
        test_reset_midrun();
        test_back_to_back();
        test_max_len();
        fill_ramp(8);
        test_stream("after_wrap", 8, 0, -1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
